// File: rtl/cfu_mac_pkg.sv
// Shared op codes, function_id field positions and FSM states for the SIMD MAC CFU.
package cfu_mac_pkg;

    localparam logic [2:0] OP_MAC        = 3'd0;
    localparam logic [2:0] OP_CLEAR      = 3'd1;
    localparam logic [2:0] OP_SET_OFFSET = 3'd2;
    localparam logic [2:0] OP_READ       = 3'd3;
    localparam logic [2:0] OP_READ_CLEAR = 3'd4;
    localparam logic [2:0] OP_CLEAR_ALL  = 3'd5;

    localparam int FID_OP_LSB     = 0;
    localparam int FID_OP_W       = 3;
    localparam int FID_SEL_LSB    = 3;
    localparam int FID_STATUS_BIT = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/cfu_simd_dot.sv
// Combinational per-lane (activation + offset) * weight products, packed lane 0 at the LSBs.
module cfu_simd_dot #(
    parameter int ELEM_W = 8
) (
    input  logic [31:0]                            a,
    input  logic [31:0]                            w,
    input  logic signed [ELEM_W:0]                 offset,
    output logic [(32/ELEM_W)*(2*ELEM_W+1)-1:0]    prod
);
    localparam int LANES  = 32 / ELEM_W;
    localparam int PROD_W = 2 * ELEM_W + 1;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [ELEM_W-1:0] a_lane;
            logic signed [ELEM_W-1:0] w_lane;
            logic signed [ELEM_W:0]   a_off;
            logic signed [PROD_W-1:0] lane_prod;

            assign a_lane = a[gi*ELEM_W +: ELEM_W];
            assign w_lane = w[gi*ELEM_W +: ELEM_W];
            // Offset add wraps at ELEM_W+1 bits; the product then fits 2*ELEM_W+1 bits exactly.
            assign a_off     = {a_lane[ELEM_W-1], a_lane} + offset;
            assign lane_prod = $signed(PROD_W'(a_off)) * $signed(PROD_W'(w_lane));
            assign prod[gi*PROD_W +: PROD_W] = lane_prod;
        end
    endgenerate

endmodule

// File: rtl/cfu_simd_mac_multi.sv
// Multi-accumulator SIMD MAC CFU: products registered at accept, reduce + accumulate in EXEC.
// Define CFU_MAC_SAT_EN for saturating accumulation with a sticky clamp status bit.
module cfu_simd_mac_multi
    import cfu_mac_pkg::*;
#(
    parameter int ELEM_W     = 8,
    parameter int ACC_N      = 4,
    parameter int ACC_W      = 32,
    parameter int OFFSET_RST = 2 ** (ELEM_W - 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);
    localparam int LANES  = 32 / ELEM_W;
    localparam int PROD_W = 2 * ELEM_W + 1;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam int WIDE_W = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;
    localparam int SEL_W  = (ACC_N > 1) ? $clog2(ACC_N) : 1;

    state_t                    state_reg;
    logic [2:0]                op_reg;
    logic [SEL_W-1:0]          sel_reg;
    logic [SEL_W-1:0]          sel_next;
    logic signed [ELEM_W:0]    offset_reg;
    logic signed [ELEM_W:0]    offset_in_reg;
    logic [LANES*PROD_W-1:0]   prod_reg;
    logic [LANES*PROD_W-1:0]   prod_next;
    logic [ACC_W-1:0]          acc_reg [ACC_N];
    logic                      rsp_valid_reg;
    logic [31:0]               rsp_payload_reg;

    logic signed [SUM_W-1:0]   lane_sum;
    logic signed [WIDE_W-1:0]  sum_wide;
    logic signed [ACC_W-1:0]   acc_cur;
    logic signed [ACC_W-1:0]   mac_result;
    logic                      unused_fid;

    assign cmd_ready             = (state_reg == ST_IDLE);
    assign rsp_valid             = rsp_valid_reg;
    assign rsp_payload_outputs_0 = rsp_payload_reg;
    assign unused_fid            = ^cmd_payload_function_id;

    generate
        if (ACC_N > 1) begin : g_sel
            assign sel_next = cmd_payload_function_id[FID_SEL_LSB +: SEL_W];
        end else begin : g_sel_single
            assign sel_next = '0;
        end
    endgenerate

    cfu_simd_dot #(.ELEM_W(ELEM_W)) u_dot (
        .a      (cmd_payload_inputs_0),
        .w      (cmd_payload_inputs_1),
        .offset (offset_reg),
        .prod   (prod_next)
    );

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + SUM_W'($signed(prod_reg[i*PROD_W +: PROD_W]));
        end
    end

    assign sum_wide = WIDE_W'(lane_sum);
    assign acc_cur  = acc_reg[sel_reg];

`ifdef CFU_MAC_SAT_EN
    localparam logic signed [WIDE_W-1:0] SAT_MAX = {{(WIDE_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] SAT_MIN = {{(WIDE_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    logic signed [WIDE_W-1:0] mac_full;
    logic                     clamp_hi;
    logic                     clamp_lo;
    logic                     sticky_reg;
    logic                     status_rd_reg;

    // Saturation judges the full-precision lane sum, not the ACC_W-truncated one.
    assign mac_full = WIDE_W'(acc_cur) + sum_wide;
    assign clamp_hi = (mac_full > SAT_MAX);
    assign clamp_lo = (mac_full < SAT_MIN);

    always_comb begin
        mac_result = mac_full[ACC_W-1:0];
        if (clamp_hi) begin
            mac_result = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (clamp_lo) begin
            mac_result = {1'b1, {(ACC_W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_reg    <= 1'b0;
            status_rd_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && cmd_valid) begin
            status_rd_reg <= cmd_payload_function_id[FID_STATUS_BIT];
        end else if (state_reg == ST_EXEC) begin
            if (op_reg == OP_MAC && (clamp_hi || clamp_lo)) begin
                sticky_reg <= 1'b1;
            end else if (op_reg == OP_READ && status_rd_reg && sel_reg == SEL_W'(ACC_N - 1)) begin
                sticky_reg <= 1'b0;
            end
        end
    end
`else
    assign mac_result = acc_cur + sum_wide[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            op_reg          <= '0;
            sel_reg         <= '0;
            offset_reg      <= (ELEM_W+1)'(OFFSET_RST);
            offset_in_reg   <= '0;
            prod_reg        <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_payload_reg <= '0;
            for (int i = 0; i < ACC_N; i++) begin
                acc_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_reg        <= cmd_payload_function_id[FID_OP_LSB +: FID_OP_W];
                        sel_reg       <= sel_next;
                        offset_in_reg <= cmd_payload_inputs_0[ELEM_W:0];
                        prod_reg      <= prod_next;
                        state_reg     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_valid_reg   <= 1'b1;
                    rsp_payload_reg <= '0;
                    state_reg       <= ST_RESP;
                    case (op_reg)
                        OP_MAC: begin
                            acc_reg[sel_reg] <= mac_result;
                            rsp_payload_reg  <= 32'(mac_result);
                        end
                        OP_CLEAR:      acc_reg[sel_reg] <= '0;
                        OP_SET_OFFSET: offset_reg <= offset_in_reg;
                        OP_READ: begin
                            rsp_payload_reg <= 32'(acc_cur);
`ifdef CFU_MAC_SAT_EN
                            if (status_rd_reg && sel_reg == SEL_W'(ACC_N - 1)) begin
                                rsp_payload_reg <= {31'd0, sticky_reg};
                            end
`endif
                        end
                        OP_READ_CLEAR: begin
                            rsp_payload_reg  <= 32'(acc_cur);
                            acc_reg[sel_reg] <= '0;
                        end
                        OP_CLEAR_ALL: begin
                            for (int i = 0; i < ACC_N; i++) begin
                                acc_reg[i] <= '0;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfu_simd_mac_multi.sv
// Self-checking bench: directed vector table, reset/saturation sequences, random ops vs. reference model.
module tb_cfu_simd_mac_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;
    logic        cmd_ready16;
    logic        rsp_valid16;
    logic [31:0] rsp_payload16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cfu_simd_mac_multi dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0)
    );

    // Narrow-accumulator instance sees the same command stream.
    cfu_simd_mac_multi #(.ACC_W(16)) dut16 (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready16),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid16),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload16)
    );

    // Reference model for the default instance (ELEM_W 8, 4 accumulators, 32-bit).
    logic [31:0] acc_m [4];
    int          off_m;

    function automatic int wrap9(input int x);
        int v;
        v = x & 511;
        if (v >= 256) v = v - 512;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) acc_m[i] = '0;
        off_m = 128;
    endfunction

    function automatic logic [31:0] model(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] w);
        int          op;
        int          s;
        longint      sum;
        longint      full;
        logic [31:0] r;
        op  = int'(fid[2:0]);
        s   = int'(fid[4:3]);
        r   = '0;
        sum = 0;
        case (op)
            0: begin
                for (int i = 0; i < 4; i++) begin
                    int ai;
                    int wi;
                    ai  = int'($signed(a[8*i +: 8]));
                    wi  = int'($signed(w[8*i +: 8]));
                    sum = sum + longint'(wrap9(ai + off_m) * wi);
                end
                full = longint'($signed(acc_m[s])) + sum;
`ifdef CFU_MAC_SAT_EN
                if (full > 64'sd2147483647) full = 64'sd2147483647;
                if (full < -64'sd2147483648) full = -64'sd2147483648;
`endif
                acc_m[s] = full[31:0];
                r = acc_m[s];
            end
            1: acc_m[s] = '0;
            2: off_m = wrap9(int'(a[8:0]));
            3: r = acc_m[s];
            4: begin r = acc_m[s]; acc_m[s] = '0; end
            5: for (int i = 0; i < 4; i++) acc_m[i] = '0;
            default: ;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One full transaction; cmd_valid is also driven during the hold to confirm it is ignored.
    task automatic do_cmd(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] w,
                          input int hold, output logic [31:0] r, output logic [31:0] r16);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid               = 1'b1;
        cmd_payload_function_id = fid;
        cmd_payload_inputs_0    = a;
        cmd_payload_inputs_1    = w;
        @(negedge clk);
        cmd_valid               = 1'b0;
        cmd_payload_function_id = 10'(4'($urandom_range(15)) << 5);
        cmd_payload_inputs_0    = $urandom;
        cmd_payload_inputs_1    = $urandom;
        chk("rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("rsp_lat2", 32'(rsp_valid), 32'd1);
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        r   = rsp_payload_outputs_0;
        r16 = rsp_payload16;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_payload", rsp_payload_outputs_0, r);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("ready_after", 32'(cmd_ready), 32'd1);
        $display("cmd fid=0x%03h in0=0x%08h in1=0x%08h -> rsp=0x%08h rsp16=0x%08h", fid, a, w, r, r16);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [9:0]  fid;
        logic [31:0] in0;
        logic [31:0] in1;
        int          hold;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    initial begin
        logic [31:0] r;
        logic [31:0] r16;
        logic [31:0] exp;
        logic [9:0]  fid;
        logic [31:0] a;
        logic [31:0] w;

        vecs[0]  = '{10'h000, 32'h01020304, 32'h01010101, 0, 32'h0000020A};
        vecs[1]  = '{10'h003, 32'h0,        32'h0,        0, 32'h0000020A};
        vecs[2]  = '{10'h008, 32'h01020304, 32'h01010101, 5, 32'h0000020A};
        vecs[3]  = '{10'h008, 32'h01020304, 32'h01010101, 0, 32'h00000414};
        vecs[4]  = '{10'h003, 32'h0,        32'h0,        1, 32'h0000020A};
        vecs[5]  = '{10'h002, 32'h0,        32'h0,        0, 32'h00000000};
        vecs[6]  = '{10'h010, 32'hFFFFFFFF, 32'h02020202, 0, 32'hFFFFFFF8};
        vecs[7]  = '{10'h00C, 32'h0,        32'h0,        0, 32'h00000414};
        vecs[8]  = '{10'h00B, 32'h0,        32'h0,        0, 32'h00000000};
        vecs[9]  = '{10'h005, 32'h0,        32'h0,        0, 32'h00000000};
        vecs[10] = '{10'h003, 32'h0,        32'h0,        0, 32'h00000000};
        vecs[11] = '{10'h013, 32'h0,        32'h0,        0, 32'h00000000};
        vecs[12] = '{10'h006, 32'h12345678, 32'h9ABCDEF0, 0, 32'h00000000};
        vecs[13] = '{10'h020, 32'h01010101, 32'h03030303, 0, 32'h0000000C};
        vecs[14] = '{10'h1E3, 32'h0,        32'h0,        0, 32'h0000000C};
        vecs[15] = '{10'h001, 32'h0,        32'h0,        0, 32'h00000000};
        vecs[16] = '{10'h003, 32'h0,        32'h0,        0, 32'h00000000};
        vecs[17] = '{10'h007, 32'hFFFFFFFF, 32'h7F7F7F7F, 2, 32'h00000000};

        reset                   = 1'b1;
        cmd_valid               = 1'b0;
        rsp_ready               = 1'b0;
        cmd_payload_function_id = '0;
        cmd_payload_inputs_0    = '0;
        cmd_payload_inputs_1    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_payload", rsp_payload_outputs_0, 32'd0);
        chk("reset_ready16", 32'(cmd_ready16), 32'd1);

        for (int i = 0; i < 18; i++) begin
            do_cmd(vecs[i].fid, vecs[i].in0, vecs[i].in1, vecs[i].hold, r, r16);
            chk($sformatf("vec%0d", i), r, vecs[i].exp);
        end

        // Reset while the MAC is in EXEC: nothing lands, response never appears.
        pulse_reset();
        cmd_valid               = 1'b1;
        cmd_payload_function_id = 10'h000;
        cmd_payload_inputs_0    = 32'h01020304;
        cmd_payload_inputs_1    = 32'h01010101;
        @(negedge clk);
        cmd_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_valid2", 32'(rsp_valid), 32'd0);
        do_cmd(10'h003, 32'h0, 32'h0, 0, r, r16);
        chk("midrst_acc0", r, 32'd0);

        // 16-bit accumulator overflow: wrap vs. saturate, then the sticky status read.
        pulse_reset();
        do_cmd(10'h002, 32'h0, 32'h0, 0, r, r16);
        exp = model(10'h002, 32'h0, 32'h0);
        exp = model(10'h000, 32'h7F7F7F7F, 32'h7F7F7F7F);
        do_cmd(10'h000, 32'h7F7F7F7F, 32'h7F7F7F7F, 0, r, r16);
        chk("big_mac32", r, exp);
`ifdef CFU_MAC_SAT_EN
        chk("sat_mac16", r16, 32'h00007FFF);
`else
        chk("wrap_mac16", r16, 32'hFFFFFC04);
`endif
        do_cmd(10'h21B, 32'h0, 32'h0, 0, r, r16);
        chk("status_rd32", r, 32'd0);
`ifdef CFU_MAC_SAT_EN
        chk("sticky16", r16, 32'd1);
`else
        chk("acc3_16", r16, 32'd0);
`endif
        do_cmd(10'h21B, 32'h0, 32'h0, 0, r, r16);
        chk("sticky16_clr", r16, 32'd0);
        exp = model(10'h21B, 32'h0, 32'h0);

        // Random ops against the reference model.
        for (int k = 0; k < 40; k++) begin
            int op;
            op = $urandom_range(9);
            if (op > 7) op = 0;
            fid = {1'b0, 4'($urandom_range(15)), 2'($urandom_range(3)), 3'(op)};
            a   = $urandom;
            w   = $urandom;
            exp = model(fid, a, w);
            do_cmd(fid, a, w, $urandom_range(2), r, r16);
            chk($sformatf("rand%0d", k), r, exp);
        end
        for (int s = 0; s < 4; s++) begin
            fid = 10'(s * 8 + 3);
            exp = model(fid, 32'h0, 32'h0);
            do_cmd(fid, 32'h0, 32'h0, 0, r, r16);
            chk($sformatf("final_acc%0d", s), r, exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
